// File: rtl/dbi_tx_pkg.sv
// Shared definitions for the DBI Type-B TX sequencer: state encoding, NOP opcode
// and elaboration-time helpers for pixel packing, stall length and counter widths.
package dbi_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST,
    ST_SRST,
    ST_WAIT,
    ST_CHK,
    ST_COL,
    ST_ROW,
    ST_DISP,
    ST_MEM
  } state_t;

  localparam logic [7:0] NOP_CMD = 8'h00;

  function automatic int calc_bpp(input int pxl_w, input int d_w);
    return pxl_w / d_w;
  endfunction

  function automatic int calc_stall_cyc(input real sec, input int clk_hz);
    int c;
    c = $rtoi(sec * clk_hz);
    return (c < 1) ? 1 : c;
  endfunction

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/dbi_pxl_serdes.sv
// Splits one PXL_W pixel into BPP bus bytes, MSB byte first; the pixel is
// released (o_pxl_rdy) on the handshake of its final byte.
module dbi_pxl_serdes
  import dbi_tx_pkg::*;
#(
  parameter int PXL_W      = 16,
  parameter int DBI_IF_D_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PXL_W-1:0]      i_pxl_d,
  input  logic                  i_hs,
  input  logic                  i_clr,
  output logic [DBI_IF_D_W-1:0] o_byte,
  output logic                  o_pxl_rdy
);

  localparam int BPP = calc_bpp(PXL_W, DBI_IF_D_W);
  localparam int BSW = clog2_min1(BPP);

  logic [BSW-1:0] r_bsel;
  logic           w_wrap;

  assign w_wrap    = (r_bsel == BSW'(BPP - 1));
  assign o_pxl_rdy = i_hs & w_wrap;

  always_comb begin
    o_byte = '0;
    for (int i = 0; i < BPP; i++) begin
      if (r_bsel == BSW'(BPP - 1 - i)) o_byte = i_pxl_d[i*DBI_IF_D_W +: DBI_IF_D_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bsel <= '0;
    end else if (i_hs) begin
      r_bsel <= (w_wrap || i_clr) ? '0 : r_bsel + BSW'(1);
    end
  end

endmodule

// File: rtl/dbi_tx_seq_ctrl.sv
// DBI Type-B TX sequencer: panel bring-up (hard/soft reset, stall, window, display-on)
// followed by continuous MEM_WR frame streaming sized from the latched window.
module dbi_tx_seq_ctrl
  import dbi_tx_pkg::*;
#(
  parameter int  INTERNAL_CLK  = 125000000,
  parameter int  DBI_IF_D_W    = 8,
  parameter int  PXL_W         = 16,
  parameter int  MAX_COL       = 320,
  parameter int  MAX_ROW       = 480,
  parameter real RST_STALL_SEC = 5e-3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dbi_tx_start_i,
  input  logic                  rst_mode_i,
  input  logic [DBI_IF_D_W-1:0] addr_soft_rst_i,
  input  logic [DBI_IF_D_W-1:0] addr_disp_on_i,
  input  logic [DBI_IF_D_W-1:0] addr_col_i,
  input  logic [DBI_IF_D_W-1:0] addr_row_i,
  input  logic [DBI_IF_D_W-1:0] addr_mem_wr_i,
  input  logic [15:0]           s_col_i,
  input  logic [15:0]           e_col_i,
  input  logic [15:0]           s_row_i,
  input  logic [15:0]           e_row_i,
  input  logic [PXL_W-1:0]      pxl_d_i,
  input  logic                  pxl_vld_i,
  output logic                  pxl_rdy_o,
  input  logic                  dtp_tx_rdy_i,
  output logic                  dtp_dbi_hrst_o,
  output logic [DBI_IF_D_W-1:0] dtp_tx_cmd_typ_o,
  output logic [DBI_IF_D_W-1:0] dtp_tx_cmd_dat_o,
  output logic                  dtp_tx_last_o,
  output logic                  dtp_tx_no_dat_o,
  output logic                  dtp_tx_vld_o,
  output logic                  frm_done_o,
  output logic                  win_err_o,
  output logic                  busy_o
);

  localparam int BPP       = calc_bpp(PXL_W, DBI_IF_D_W);
  localparam int STALL_CYC = calc_stall_cyc(RST_STALL_SEC, INTERNAL_CLK);
  localparam int SCW       = clog2_min1(STALL_CYC);
  localparam int BCW       = clog2_min1(MAX_COL * MAX_ROW * BPP);
  localparam logic [DBI_IF_D_W-1:0] NOP = DBI_IF_D_W'(NOP_CMD);

  state_t r_state, w_state_nxt;

  logic [1:0]     r_cnt;
  logic [SCW-1:0] r_stall_cnt;
  logic [BCW-1:0] r_byte_cnt;
  logic [BCW-1:0] r_nbyte_m1;
  logic [15:0]    r_s_col, r_e_col, r_s_row, r_e_row;

  logic                  w_vld, w_hs, w_mem_hs, w_last;
  logic [16:0]           w_col_n, w_row_n;
  logic                  w_win_bad;
  logic [39:0]           w_nbyte_full;
  logic [DBI_IF_D_W-1:0] w_pxl_byte;

  function automatic logic [DBI_IF_D_W-1:0] win_byte(input logic [15:0] s, input logic [15:0] e,
                                                     input logic [1:0] idx);
    case (idx)
      2'd0:    return DBI_IF_D_W'(s[15:8]);
      2'd1:    return DBI_IF_D_W'(s[7:0]);
      2'd2:    return DBI_IF_D_W'(e[15:8]);
      default: return DBI_IF_D_W'(e[7:0]);
    endcase
  endfunction

  // Window extents are computed at 17 bits so a full 0..FFFF span cannot wrap.
  assign w_col_n      = {1'b0, r_e_col} - {1'b0, r_s_col} + 17'd1;
  assign w_row_n      = {1'b0, r_e_row} - {1'b0, r_s_row} + 17'd1;
  assign w_win_bad    = (r_e_col < r_s_col) || (w_col_n > 17'(MAX_COL)) ||
                        (r_e_row < r_s_row) || (w_row_n > 17'(MAX_ROW));
  assign w_nbyte_full = 40'(w_col_n) * 40'(w_row_n) * 40'(BPP);

  assign w_vld    = (r_state == ST_RST) || (r_state == ST_SRST) || (r_state == ST_COL) ||
                    (r_state == ST_ROW) || (r_state == ST_DISP) ||
                    ((r_state == ST_MEM) && pxl_vld_i);
  assign w_hs     = w_vld & dtp_tx_rdy_i;
  assign w_mem_hs = (r_state == ST_MEM) & w_hs;
  assign w_last   = (r_state == ST_MEM) && (r_byte_cnt == r_nbyte_m1);

  assign dtp_tx_vld_o = w_vld;
  assign busy_o       = (r_state != ST_IDLE);

  dbi_pxl_serdes #(
    .PXL_W      (PXL_W),
    .DBI_IF_D_W (DBI_IF_D_W)
  ) u_serdes (
    .clk       (clk),
    .rst       (rst),
    .i_pxl_d   (pxl_d_i),
    .i_hs      (w_mem_hs),
    .i_clr     (w_mem_hs & w_last),
    .o_byte    (w_pxl_byte),
    .o_pxl_rdy (pxl_rdy_o)
  );

  always_comb begin
    w_state_nxt      = r_state;
    dtp_dbi_hrst_o   = 1'b0;
    dtp_tx_cmd_typ_o = NOP;
    dtp_tx_cmd_dat_o = NOP;
    dtp_tx_last_o    = 1'b0;
    dtp_tx_no_dat_o  = 1'b0;
    frm_done_o       = 1'b0;
    win_err_o        = 1'b0;
    case (r_state)
      ST_IDLE: if (dbi_tx_start_i) w_state_nxt = rst_mode_i ? ST_SRST : ST_RST;
      ST_RST: begin
        dtp_dbi_hrst_o = 1'b1;
        if (w_hs) w_state_nxt = ST_WAIT;
      end
      ST_SRST: begin
        dtp_tx_cmd_typ_o = addr_soft_rst_i;
        dtp_tx_no_dat_o  = 1'b1;
        if (w_hs) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: if (r_stall_cnt == '0) w_state_nxt = ST_CHK;
      ST_CHK: begin
        win_err_o   = w_win_bad;
        w_state_nxt = w_win_bad ? ST_IDLE : ST_COL;
      end
      ST_COL: begin
        dtp_tx_cmd_typ_o = addr_col_i;
        dtp_tx_cmd_dat_o = win_byte(r_s_col, r_e_col, r_cnt);
        if (w_hs && (r_cnt == 2'd3)) w_state_nxt = ST_ROW;
      end
      ST_ROW: begin
        dtp_tx_cmd_typ_o = addr_row_i;
        dtp_tx_cmd_dat_o = win_byte(r_s_row, r_e_row, r_cnt);
        if (w_hs && (r_cnt == 2'd3)) w_state_nxt = ST_DISP;
      end
      ST_DISP: begin
        dtp_tx_cmd_typ_o = addr_disp_on_i;
        dtp_tx_no_dat_o  = 1'b1;
        if (w_hs) w_state_nxt = ST_MEM;
      end
      ST_MEM: begin
        dtp_tx_cmd_typ_o = addr_mem_wr_i;
        dtp_tx_cmd_dat_o = w_pxl_byte;
        dtp_tx_last_o    = w_last;
        // A stop request only takes effect on the frame's closing handshake.
        if (w_hs && w_last) begin
          frm_done_o = 1'b1;
          if (!dbi_tx_start_i) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
      r_byte_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_RST, ST_SRST: if (w_hs) r_stall_cnt <= SCW'(STALL_CYC - 1);
        ST_WAIT:         if (r_stall_cnt != '0) r_stall_cnt <= r_stall_cnt - SCW'(1);
        ST_CHK:          r_cnt <= '0;
        ST_COL, ST_ROW:  if (w_hs) r_cnt <= r_cnt + 2'd1;
        ST_MEM:          if (w_hs) r_byte_cnt <= w_last ? '0 : r_byte_cnt + BCW'(1);
        default: ;
      endcase
    end
  end

  // Window and frame size are data: captured at start / CHK, never reset.
  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && dbi_tx_start_i) begin
      r_s_col <= s_col_i;
      r_e_col <= e_col_i;
      r_s_row <= s_row_i;
      r_e_row <= e_row_i;
    end
    if ((r_state == ST_CHK) && !w_win_bad) r_nbyte_m1 <= BCW'(w_nbyte_full - 40'd1);
  end

endmodule
